morse_decoder: RTL and testbench

- Parametrised successor to the fixed-timing Morse block.
- Samples a single serial key line (`in`), times marks and spaces in clock cycles, and classifies each mark as dot or dash.
- Decodes letters A–Z and digits 0–9 to 8-bit ASCII on `out`, and emits an ASCII space on a word gap.
- Sits between a key/GPIO input and a character sink such as a UART TX or display buffer.

---
 rtl/morse_decoder_if.sv | 11 +
 rtl/morse_decoder.sv | 192 +++++++++++++++++++
 tb/tb_morse_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Key-line and character-output bundle for morse_decoder.
// master: key source / character sink side; slave: the decoder.
interface morse_decoder_if;
    logic       in;
    logic [7:0] out;
    logic       out_valid;
    logic       err;

    modport master (output in, input out, input out_valid, input err);
    modport slave  (input in, output out, output out_valid, output err);
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder: times marks/spaces on a registered key line, classifies
// dot/dash, and emits ASCII A-Z / 0-9 on letter gaps and 0x20 on word gaps.
// Invalid or overflowing codes emit 0x3F with err.
// Optional input deglitch filter: define MORSE_DEGLITCH_EN.
module morse_decoder #(
    parameter int unsigned DOT_MAX    = 3,
    parameter int unsigned LETTER_GAP = 4,
    parameter int unsigned WORD_GAP   = 10,
    parameter int unsigned MAX_SYM    = 5,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEGLITCH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    morse_decoder_if.slave   bus
);
    localparam int unsigned LEN_W = $clog2(MAX_SYM + 2);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, WGAP} state_t;

    state_t             state, state_n;
    logic               s_in;
    logic               k;
    logic [CNT_W-1:0]   mark_cnt, mark_n, mark_inc;
    logic [CNT_W-1:0]   space_cnt, space_n, space_inc;
    logic [MAX_SYM-1:0] code;
    logic [LEN_W-1:0]   len;
    logic               push, dash_bit, clr, emit, emit_err;
    logic [7:0]         emit_ch;
    logic [8:0]         dec;

    // Maps a symbol count and MSB-first code (dot=0, dash=1) to {err, ascii}.
    function automatic logic [8:0] decode(input int unsigned n, input logic [4:0] c);
        logic [7:0] ch;
        ch = 8'h3F;
        case (n)
            1: ch = c[0] ? "T" : "E";
            2: case (c[1:0])
                2'b00: ch = "I";  2'b01: ch = "A";
                2'b10: ch = "N";  default: ch = "M";
            endcase
            3: case (c[2:0])
                3'b000: ch = "S";  3'b001: ch = "U";  3'b010: ch = "R";  3'b011: ch = "W";
                3'b100: ch = "D";  3'b101: ch = "K";  3'b110: ch = "G";  default: ch = "O";
            endcase
            4: case (c[3:0])
                4'b0000: ch = "H";  4'b0001: ch = "V";  4'b0010: ch = "F";  4'b0100: ch = "L";
                4'b0110: ch = "P";  4'b0111: ch = "J";  4'b1000: ch = "B";  4'b1001: ch = "X";
                4'b1010: ch = "C";  4'b1011: ch = "Y";  4'b1100: ch = "Z";  4'b1101: ch = "Q";
                default: ch = 8'h3F;
            endcase
            5: case (c)
                5'b01111: ch = "1";  5'b00111: ch = "2";  5'b00011: ch = "3";  5'b00001: ch = "4";
                5'b00000: ch = "5";  5'b10000: ch = "6";  5'b11000: ch = "7";  5'b11100: ch = "8";
                5'b11110: ch = "9";  5'b11111: ch = "0";
                default: ch = 8'h3F;
            endcase
            default: ch = 8'h3F;
        endcase
        return {ch == 8'h3F, ch};
    endfunction

    // Input register: all timing is taken from the sampled key line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) s_in <= 1'b0;
        else        s_in <= bus.in;
    end

`ifdef MORSE_DEGLITCH_EN
    localparam int unsigned DG_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
    logic            s2, filt;
    logic [DG_W-1:0] dg_cnt;

    // Second sync stage plus filter: follow s2 only after DEGLITCH stable cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2     <= 1'b0;
            filt   <= 1'b0;
            dg_cnt <= '0;
        end else begin
            s2 <= s_in;
            if (s2 == filt) begin
                dg_cnt <= '0;
            end else if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
                filt   <= s2;
                dg_cnt <= '0;
            end else begin
                dg_cnt <= dg_cnt + 1'b1;
            end
        end
    end
    assign k = filt;
`else
    assign k = s_in;
`endif

    // Decoder result for the current buffer; lengths past MAX_SYM are overflow.
    always_comb begin
        if (32'(len) > MAX_SYM) dec = {1'b1, 8'h3F};
        else                    dec = decode(32'(len), 5'(code));
    end

    // Next-state, counter and emission logic.
    always_comb begin
        state_n   = state;
        mark_n    = mark_cnt;
        space_n   = space_cnt;
        push      = 1'b0;
        dash_bit  = 1'b0;
        clr       = 1'b0;
        emit      = 1'b0;
        emit_err  = 1'b0;
        emit_ch   = '0;
        mark_inc  = (mark_cnt == '1)  ? mark_cnt  : mark_cnt + 1'b1;
        space_inc = (space_cnt == '1) ? space_cnt : space_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (k) begin
                    state_n = MARK;
                    mark_n  = CNT_W'(1);
                end
            end
            MARK: begin
                if (k) begin
                    mark_n = mark_inc;
                end else begin
                    push     = 1'b1;
                    dash_bit = (mark_cnt > CNT_W'(DOT_MAX));
                    state_n  = SPACE;
                    space_n  = CNT_W'(1);
                end
            end
            SPACE: begin
                if (k) begin
                    state_n = MARK;
                    mark_n  = CNT_W'(1);
                end else begin
                    space_n = space_inc;
                    if (space_inc == CNT_W'(LETTER_GAP)) begin
                        emit     = 1'b1;
                        emit_ch  = dec[7:0];
                        emit_err = dec[8];
                        clr      = 1'b1;
                        state_n  = WGAP;
                    end
                end
            end
            WGAP: begin
                if (k) begin
                    state_n = MARK;
                    mark_n  = CNT_W'(1);
                end else begin
                    space_n = space_inc;
                    if (space_inc == CNT_W'(WORD_GAP)) begin
                        emit    = 1'b1;
                        emit_ch = 8'h20;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters, symbol buffer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mark_cnt      <= '0;
            space_cnt     <= '0;
            code          <= '0;
            len           <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_n;
            mark_cnt      <= mark_n;
            space_cnt     <= space_n;
            bus.out_valid <= emit;
            bus.err       <= emit & emit_err;
            if (emit) bus.out <= emit_ch;
            if (clr) begin
                code <= '0;
                len  <= '0;
            end else if (push) begin
                code <= (code << 1) | MAX_SYM'(dash_bit);
                if (32'(len) <= MAX_SYM) len <= len + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder (default build, no deglitch).
module tb_morse_decoder;
    logic clk;
    logic reset;
    morse_decoder_if bus();

    morse_decoder dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned nsym;
        logic [7:0]  sym;
        int unsigned dot_len;
        int unsigned dash_len;
        logic [7:0]  ch;
        logic        er;
    } vec_t;

    typedef struct {
        logic [7:0] ch;
        logic       er;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned nvec = 0;
    int unsigned nmis = 0;
    int unsigned cyc_no = 0;
    int unsigned last_v = 0;
    int unsigned prev_v = 0;

    always @(posedge clk) cyc_no++;

    // Scoreboard: every output pulse is popped against the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.err && !bus.out_valid) begin
                nvec++; nmis++;
                $display("FAIL err_without_valid: err=%b out_valid=%b required err=0", bus.err, bus.out_valid);
            end
            if (bus.out_valid) begin
                prev_v = last_v;
                last_v = cyc_no;
                nvec++;
                if (exp_q.size() == 0) begin
                    nmis++;
                    $display("FAIL unexpected_output: out=%h err=%b required no pulse", bus.out, bus.err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.out !== e.ch || bus.err !== e.er) begin
                        nmis++;
                        $display("FAIL char: out=%h err=%b required out=%h err=%b", bus.out, bus.err, e.ch, e.er);
                    end
                end
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int unsigned n);
        bus.in = v;
        cyc(n);
    endtask

    task automatic expect_ch(input logic [7:0] ch, input logic er);
        exp_t e;
        e.ch = ch;
        e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic send_letter(input vec_t v);
        for (int i = 0; i < int'(v.nsym); i++) begin
            drive(1'b1, v.sym[v.nsym - 1 - i] ? v.dash_len : v.dot_len);
            if (i != int'(v.nsym) - 1) drive(1'b0, 1);
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    vec_t tbl[13];

    initial begin
        vec_t dot;
        tbl[0]  = '{3, 8'b000,   2, 4,   8'h53, 1'b0}; // S
        tbl[1]  = '{1, 8'b0,     3, 4,   8'h45, 1'b0}; // 3-cycle mark = dot: E
        tbl[2]  = '{1, 8'b1,     2, 4,   8'h54, 1'b0}; // 4-cycle mark = dash: T
        tbl[3]  = '{3, 8'b111,   2, 4,   8'h4F, 1'b0}; // O
        tbl[4]  = '{2, 8'b01,    2, 4,   8'h41, 1'b0}; // A
        tbl[5]  = '{4, 8'b1101,  2, 4,   8'h51, 1'b0}; // Q
        tbl[6]  = '{5, 8'b11111, 2, 4,   8'h30, 1'b0}; // 0
        tbl[7]  = '{5, 8'b00000, 2, 4,   8'h35, 1'b0}; // 5
        tbl[8]  = '{5, 8'b11000, 2, 4,   8'h37, 1'b0}; // 7
        tbl[9]  = '{4, 8'b0101,  2, 4,   8'h3F, 1'b1}; // unassigned .-.-
        tbl[10] = '{6, 8'b0,     2, 4,   8'h3F, 1'b1}; // overflow
        tbl[11] = '{4, 8'b1111,  2, 4,   8'h3F, 1'b1}; // unassigned ----
        tbl[12] = '{1, 8'b1,     2, 300, 8'h54, 1'b0}; // saturating mark: T
        dot = '{1, 8'b0, 2, 4, 8'h45, 1'b0};

        bus.in = 1'b0;
        reset  = 1'b0;
        cyc(3);
        check("reset_out", bus.out, 8'h00);
        check("reset_valid", {7'd0, bus.out_valid}, 8'h00);
        check("reset_err", {7'd0, bus.err}, 8'h00);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 13; i++) begin
            expect_ch(tbl[i].ch, tbl[i].er);
            send_letter(tbl[i]);
            drive(1'b0, 6);
        end
        expect_ch(8'h20, 1'b0);
        drive(1'b0, 12);

        // Gap of LETTER_GAP-1 lows keeps the letter open: I
        expect_ch(8'h49, 1'b0);
        send_letter(dot);
        drive(1'b0, 3);
        send_letter(dot);
        drive(1'b0, 6);
        expect_ch(8'h20, 1'b0);
        drive(1'b0, 8);

        // Gap of exactly LETTER_GAP lows closes it: E E
        expect_ch(8'h45, 1'b0);
        send_letter(dot);
        drive(1'b0, 4);
        expect_ch(8'h45, 1'b0);
        send_letter(dot);
        drive(1'b0, 6);
        expect_ch(8'h20, 1'b0);
        drive(1'b0, 8);

        // Word gap: T then space six cycles later, then silence
        expect_ch(8'h54, 1'b0);
        expect_ch(8'h20, 1'b0);
        drive(1'b1, 4);
        drive(1'b0, 40);
        check("word_gap_spacing", 8'(last_v - prev_v), 8'd6);
        check("out_holds", bus.out, 8'h20);

        // Asynchronous reset in the middle of a dash
        drive(1'b1, 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_out", bus.out, 8'h00);
        check("async_reset_valid", {7'd0, bus.out_valid}, 8'h00);
        bus.in = 1'b0;
        cyc(2);
        reset = 1'b1;
        drive(1'b0, 3);
        expect_ch(8'h41, 1'b0);
        send_letter(tbl[4]);
        drive(1'b0, 6);
        expect_ch(8'h20, 1'b0);
        drive(1'b0, 8);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc(1);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
